// File: rtl/gat_pkg.sv
// Shared GAT definitions: read-back FSM states and the derived feature-BRAM geometry.
package gat_pkg;

    localparam int NUM_SUBGRAPHS      = 2708;
    localparam int NUM_FEATURE_OUT    = 16;
    localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT;
    localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH);

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN,
        RD_DRAIN,
        RD_DONE
    } rd_state_e;

endpackage

// File: rtl/gat_sync_fifo.sv
// Single-clock FIFO with registered storage; the head entry is visible on rd_data whenever not empty.
module gat_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_wr) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

endmodule

// File: rtl/gat_feat_bram_reader.sv
// Walks the new-feature BRAM, packs four 8-bit features per word and streams them out over AXI-Stream.
module gat_feat_bram_reader #(
    parameter int DATA_WIDTH         = 8,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int RD_LATENCY         = 2,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [31:0]                   feat_bram_dout,
    output logic [31:0]                   m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast
);

    import gat_pkg::*;

    localparam int OCC_W = $clog2(4 * FIFO_DEPTH) + 1;
    localparam int CNT_W = NEW_FEATURE_ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [OCC_W-1:0] CREDIT   = OCC_W'(4 * FIFO_DEPTH);

    rd_state_e state;
    rd_state_e state_next;

    logic [CNT_W-1:0]              issue_cnt;
    logic [CNT_W-1:0]              cap_cnt;
    logic [OCC_W-1:0]              occ;
    logic [RD_LATENCY-1:0]         vld_sr;
    logic [31:0]                   packer;
    logic [31:0]                   word_c;
    logic [NEW_FEATURE_ADDR_W+1:0] addr_hold;
    logic [1:0]                    lane;
    logic [1:0]                    pad;
    logic                          accept;
    logic                          issue;
    logic                          capture;
    logic                          cap_last;
    logic                          push;
    logic                          pop;

    logic [32:0]                   fifo_rd_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          unused_bits;

    assign unused_bits = ^{feat_bram_dout[31:DATA_WIDTH], fifo_full, fifo_count};

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RD_RUN;
                end
            end
            RD_RUN: begin
                busy  = 1'b1;
                issue = (occ < CREDIT);
                if (issue && (issue_cnt == LAST_IDX)) begin
                    state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                busy = 1'b1;
                if (pop && m_tlast) begin
                    state_next = RD_DONE;
                end
            end
            RD_DONE: begin
                done       = 1'b1;
                state_next = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // A short final word reserves its empty lanes in occ so the pop that frees it balances out.
    always_comb begin
        lane     = cap_cnt[1:0];
        capture  = vld_sr[RD_LATENCY-1];
        cap_last = capture && (cap_cnt == LAST_IDX);
        push     = capture && ((lane == 2'd3) || cap_last);
        pad      = cap_last ? (2'd3 - lane) : 2'd0;
        pop      = m_tvalid && m_tready;
        word_c   = packer;
        word_c[{lane, 3'b000} +: DATA_WIDTH] = feat_bram_dout[DATA_WIDTH-1:0];
        feat_bram_addrb = issue ? {issue_cnt[NEW_FEATURE_ADDR_W-1:0], 2'b00} : addr_hold;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            cap_cnt   <= '0;
            occ       <= '0;
            vld_sr    <= '0;
            packer    <= '0;
            addr_hold <= '0;
        end else begin
            vld_sr    <= (vld_sr << 1) | RD_LATENCY'(issue);
            addr_hold <= feat_bram_addrb;
            if (accept) begin
                issue_cnt <= '0;
                cap_cnt   <= '0;
                occ       <= '0;
                packer    <= '0;
                addr_hold <= '0;
            end else begin
                if (issue) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                end
                if (capture) begin
                    cap_cnt <= cap_cnt + CNT_W'(1);
                    packer  <= push ? 32'd0 : word_c;
                end
                occ <= occ + OCC_W'(issue) + OCC_W'(pad) - (pop ? OCC_W'(4) : OCC_W'(0));
            end
        end
    end

    gat_sync_fifo #(
        .WIDTH (33),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data ({cap_last, word_c}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_tvalid = !fifo_empty;
    assign m_tdata  = fifo_empty ? 32'd0 : fifo_rd_data[31:0];
    assign m_tlast  = !fifo_empty && fifo_rd_data[32];

endmodule
